// File: rtl/fp_align_if.sv
// fp_align_if: operand/result bundle for the fp_align exponent-alignment block.
//   Requester side (master) drives START, MODE_FP, MANT_A/B, EXP_A/B.
//   Aligner side (slave) drives mant_big, mant_small, exp, swapped, sticky,
//   exp_err, busy and done.
interface fp_align_if;
  logic        START;
  logic        MODE_FP;
  logic [48:0] MANT_A;
  logic [48:0] MANT_B;
  logic [8:0]  EXP_A;
  logic [8:0]  EXP_B;
  logic [48:0] mant_big;
  logic [48:0] mant_small;
  logic [8:0]  exp;
  logic        swapped;
  logic        sticky;
  logic        exp_err;
  logic        busy;
  logic        done;

  modport master (
    output START, MODE_FP, MANT_A, MANT_B, EXP_A, EXP_B,
    input  mant_big, mant_small, exp, swapped, sticky, exp_err, busy, done
  );

  modport slave (
    input  START, MODE_FP, MANT_A, MANT_B, EXP_A, EXP_B,
    output mant_big, mant_small, exp, swapped, sticky, exp_err, busy, done
  );
endinterface

// File: rtl/fp_align.sv
// fp_align: aligns two floating-point mantissas to a common exponent.
//   CLK   - clock, rising edge active
//   RST_N - asynchronous active-low reset
//   bus   - fp_align_if.slave: operands in; aligned result, sticky, exp_err,
//           busy and a one-cycle done pulse out.
// The smaller-exponent mantissa is shifted right one bit per cycle in SHIFT;
// differences of 49 or more collapse straight to zero plus sticky.
module fp_align (
  input  logic        CLK,
  input  logic        RST_N,
  fp_align_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [48:0] mant_big_q, mant_big_d;
  logic [48:0] mant_small_q, mant_small_d;
  logic [8:0]  exp_q, exp_d;
  logic        swapped_q, swapped_d;
  logic        sticky_q, sticky_d;
  logic        exp_err_q, exp_err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  count_q, count_d;

  logic        swap_s;
  logic [48:0] in_big_mant_s;
  logic [48:0] in_small_mant_s;
  logic [8:0]  in_big_exp_s;
  logic [8:0]  in_small_exp_s;
  logic [8:0]  diff_s;
  logic [8:0]  max_exp_s;

  // Operand ordering: ties keep A as the big operand.
  assign swap_s          = (bus.EXP_A < bus.EXP_B);
  assign in_big_mant_s   = swap_s ? bus.MANT_B : bus.MANT_A;
  assign in_small_mant_s = swap_s ? bus.MANT_A : bus.MANT_B;
  assign in_big_exp_s    = swap_s ? bus.EXP_B  : bus.EXP_A;
  assign in_small_exp_s  = swap_s ? bus.EXP_A  : bus.EXP_B;
  assign diff_s          = in_big_exp_s - in_small_exp_s;
  assign max_exp_s       = bus.MODE_FP ? 9'd254 : 9'd30;

  // Next-state and next-output computation.
  always_comb begin
    state_d      = state_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    exp_d        = exp_q;
    swapped_d    = swapped_q;
    sticky_d     = sticky_q;
    exp_err_d    = exp_err_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    count_d      = count_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          mant_big_d = in_big_mant_s;
          exp_d      = in_big_exp_s;
          swapped_d  = swap_s;
          sticky_d   = 1'b0;
          exp_err_d  = (bus.EXP_A > max_exp_s) || (bus.EXP_B > max_exp_s);
          busy_d     = 1'b1;
          if (diff_s == 9'd0) begin
            mant_small_d = in_small_mant_s;
            count_d      = 6'd0;
            done_d       = 1'b1;
            state_d      = DONE;
          end else if (diff_s >= 9'd49) begin
            // Every bit would be shifted out: skip the walk entirely.
            mant_small_d = 49'd0;
            sticky_d     = |in_small_mant_s;
            count_d      = 6'd0;
            done_d       = 1'b1;
            state_d      = DONE;
          end else begin
            mant_small_d = in_small_mant_s;
            count_d      = diff_s[5:0];
            state_d      = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        mant_small_d = {1'b0, mant_small_q[48:1]};
        sticky_d     = sticky_q | mant_small_q[0];
        count_d      = count_q - 6'd1;
        if (count_q == 6'd1) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        count_d = 6'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      mant_big_q   <= 49'd0;
      mant_small_q <= 49'd0;
      exp_q        <= 9'd0;
      swapped_q    <= 1'b0;
      sticky_q     <= 1'b0;
      exp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= 6'd0;
    end else begin
      state_q      <= state_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      exp_q        <= exp_d;
      swapped_q    <= swapped_d;
      sticky_q     <= sticky_d;
      exp_err_q    <= exp_err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  assign bus.mant_big   = mant_big_q;
  assign bus.mant_small = mant_small_q;
  assign bus.exp        = exp_q;
  assign bus.swapped    = swapped_q;
  assign bus.sticky     = sticky_q;
  assign bus.exp_err    = exp_err_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port START, input, 1 bit: request to align; accepted only in IDLE.
REQ-004 SHALL have port MODE_FP, input, 1 bit: 0 = half, 1 = single; sampled at accept.
REQ-005 SHALL have ports MANT_A and MANT_B, inputs, 49 bits each: operand mantissas, hidden bit at [47].
REQ-006 SHALL have ports EXP_A and EXP_B, inputs, 9 bits each: biased operand exponents.
REQ-007 SHALL have ports mant_big and mant_small, outputs, 49 bits each: larger-exponent mantissa (unchanged) and aligned smaller-exponent mantissa.
REQ-008 SHALL have port exp, output, 9 bits: common exponent (the larger input exponent).
REQ-009 SHALL have port swapped, output, 1 bit: 1 when the B operand drives mant_big.
REQ-010 SHALL have port sticky, output, 1 bit: OR of all bits shifted out of mant_small.
REQ-011 SHALL have port exp_err, output, 1 bit: either input exponent exceeds MAX_EXP for MODE_FP.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-014 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-015 SHALL accept an operation on a rising edge in IDLE with START=1, and SHALL ignore START in every other state.
REQ-016 On accept, if EXP_A >= EXP_B, SHALL load big={MANT_A,EXP_A} and small={MANT_B,EXP_B} with swapped=0; otherwise SHALL load the swapped pair with swapped=1.
REQ-017 On accept, SHALL compute d = exp_big - exp_small as 9-bit unsigned, load exp=exp_big, clear sticky, and register exp_err.
REQ-018 SHALL use MAX_EXP = 254 when MODE_FP=1 and MAX_EXP = 30 when MODE_FP=0.
REQ-019 On accept with d=0, SHALL go to DONE with mant_small equal to the input unchanged.
REQ-020 On accept with d>=49, SHALL load mant_small=0 and sticky=|small mantissa, and SHALL go to DONE.
REQ-021 On accept with 1<=d<=48, SHALL load the shift counter with d and go to SHIFT.
REQ-022 In SHIFT, each cycle SHALL perform mant_small <= mant_small>>1 (zero fill), sticky <= sticky | mant_small[0], and count <= count-1; it SHALL leave SHIFT for DONE on the cycle in which count goes 1->0.
REQ-023 SHALL assert done=1 only while in DONE, and DONE SHALL always go to IDLE on the next edge.
REQ-024 Latency: done SHALL be high in the first cycle after accept for d=0 or d>=49, and in cycle d+1 after accept for 1<=d<=48.
REQ-025 SHALL hold mant_big, mant_small, exp, swapped, sticky and exp_err stable from DONE until the next accept.
REQ-026 START high in the DONE cycle SHALL be ignored; START sampled in the following IDLE cycle SHALL be accepted, so back-to-back operations are separated by at least one idle cycle.
REQ-027 exp_err SHALL be informational only: alignment proceeds normally when it is set.

Reset
REQ-028 While RST_N=0, state SHALL be IDLE and all outputs and internal registers SHALL be 0, including the counter; this holds immediately, independent of CLK.
REQ-029 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse; the first START after release SHALL be accepted normally.

Verification
REQ-030 MANT_A=0x0_8000_0000_0000, EXP_A=130, MANT_B=0x0_C000_0000_0000, EXP_B=128, START=1 -> done 3 cycles after accept; mant_small=0x0_3000_0000_0000, exp=130, swapped=0, sticky=0.
REQ-031 EXP_A=100, EXP_B=105, MANT_A=0x0_8000_0000_0007 -> swapped=1, exp=105, mant_small=0x0_0400_0000_0000, sticky=1, done in cycle 6.
REQ-032 EXP_A=200, EXP_B=20, MANT_B=1 -> done in cycle 1, mant_small=0, sticky=1; repeat with MANT_B=0 -> sticky=0.
REQ-033 EXP_A=EXP_B=15, MODE_FP=0 -> done in cycle 1, swapped=0, mant_small=MANT_B; repeat with EXP_A=31 -> exp_err=1.
REQ-034 Pulse START every cycle during a d=10 operation -> exactly one done pulse, and the results match the first operand set.
REQ-035 Assert RST_N=0 mid-SHIFT -> outputs read 0 immediately, busy=0, no done pulse; a new START after release yields a correct result.
